qspi_page_write_sequencer: RTL and testbench
============================================

// Module: qspi_page_write_sequencer
// PURPOSE
//  Sequences qspi_mem_controller through a full flash page write: WREN, RDSR(WEL check), optional SE+WIP poll,
//  WREN, RDSR(WEL), PP, WIP poll. Sits between a page-write requester and the controller. Drives trigger/cmd/data_send.
//  Reports one done pulse or a sticky fail code. Opcodes are the `CMD_* macros of defs.vh: WREN, RDSR, SE, PP.
// PARAMETERS
//  POLL_GAP       64           idle cycles between consecutive RDSR commands while polling WIP
//  TIMEOUT_CYCLES 160_000_000  max cycles in one WIP-poll phase (4 s at 40 MHz) before failing
// PORTS
//  clk           in   1     system clock (controller clock domain)
//  reset         in   1     synchronous, active-low reset
//  req_valid     in   1     page-write request
//  req_ready     out  1     comb: (state==IDLE) && !mc_busy
//  req_erase     in   1     1: sector-erase req_addr's sector before programming
//  req_addr      in   24    flash byte address of page
//  req_data      in   2048  256 page bytes, byte 0 in [2047:2040]
//  done          out  1     1-cycle pulse: write sequence completed without error
//  fail          out  1     sticky failure flag; cleared on next accepted request
//  fail_code     out  2     0 none, 1 WEL not set, 2 controller error, 3 WIP timeout
//  seq_busy      out  1     high from acceptance until done/fail
//  mc_trigger    out  1     1-cycle command start pulse to controller
//  mc_cmd        out  8     opcode to controller
//  mc_data_send  out  2072  {addr[23:0], data[2047:0]} to controller
//  mc_readout    in   8     last byte read by controller (RDSR status)
//  mc_busy       in   1     controller busy
//  mc_error      in   1     controller error, valid when mc_busy low after a command
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state IDLE; mc_trigger 0, mc_cmd 0, mc_data_send 0, done 0, fail 0,
//    fail_code 0, seq_busy 0, counters 0. Reset mid-sequence abandons it silently, with no done and no fail.
//  Accept on req_valid && req_ready. Latch addr/data/erase, clear fail/fail_code, set seq_busy.
//  Command issue (every step): cycle N: mc_cmd, mc_data_send set, mc_trigger=1. N+1: mc_trigger=0 (SETTLE).
//    From N+2: wait mc_busy==0, then sample mc_error/mc_readout (CHECK). Exactly one trigger per command.
//  mc_data_send: SE = {addr, 2048'h0}; PP = {addr, data}; WREN/RDSR hold previous value.
//  Step order: [erase] WREN -> RDSR(WEL) -> SE -> POLL; then WREN -> RDSR(WEL) -> PP -> POLL -> DONE.
//  WEL check: RDSR readout[1]==0 -> FAIL code 1. No retry, no further commands.
//  POLL: RDSR, CHECK readout[0] (WIP). WIP=1: wait POLL_GAP idle cycles, reissue RDSR. WIP=0: next step.
//    Timeout counter clears on POLL entry and counts every cycle in POLL, including gaps and command time.
//    Count reaching TIMEOUT_CYCLES -> FAIL code 3 at the next CHECK or gap cycle. An in-flight command always
//    completes first (never abort while mc_busy).
//  mc_error==1 at any CHECK -> FAIL code 2. Takes priority over WEL/WIP evaluation of the same readout.
//  DONE: done=1 for one cycle, seq_busy=0, -> IDLE. FAIL: fail=1, fail_code set, seq_busy=0, -> IDLE.
//  A request presented while mc_busy is high (e.g. after reset) is held off by req_ready=0. No request queuing.
//  A CHECK result that is both WIP=1 and timed out gives code 3. A WIP=0 result at the expiry cycle gives success.
// TESTING
//  1 Program, erase=0, model WIP=1 for 3 RDSR then 0 -> cmds WREN,RDSR,PP,RDSR x4; one done; fail=0.
//  2 Erase=1, addr 24'hA30000 -> WREN,RDSR,SE(data_send[2071:2048]=A30000),polls,WREN,RDSR,PP; done once.
//  3 Model RDSR after WREN returns 8'h00 -> fail=1, code 1, PP/SE never issued, req_ready back high.
//  4 mc_error=1 at end of PP -> fail code 2; no RDSR issued after PP.
//  5 TIMEOUT_CYCLES=1000, WIP stuck 1 -> fail code 3 within 1000+POLL_GAP+1 command time; trigger gaps >= POLL_GAP.
//  6 reset low for 1 cycle mid-POLL -> mc_trigger 0 and no done/fail; req_ready high only after mc_busy low;
//    next request completes normally.

Source files
------------

// File: rtl/qspi_page_write_sequencer.sv
// qspi_page_write_sequencer
//   Walks a QSPI memory controller through one complete flash page write:
//   [WREN, RDSR(WEL), SE, WIP poll,] WREN, RDSR(WEL), PP, WIP poll.
//   Each command is launched with a one-cycle mc_trigger. The cycle after the
//   trigger is a settle cycle. The sequencer then waits for mc_busy to drop and
//   evaluates mc_error/mc_readout. Success ends with a one-cycle done pulse.
//   Failure ends with a sticky fail flag and a fail_code.
// Ports
//   clk, reset          clock; synchronous active-low reset
//   req_valid/ready     page-write handshake (ready = idle and controller idle)
//   req_erase           erase the addressed sector before programming
//   req_addr, req_data  page address; 256 bytes, byte 0 in [2047:2040]
//   done                one-cycle success pulse
//   fail, fail_code     sticky failure: 1 WEL not set, 2 controller error,
//                       3 WIP timeout
//   seq_busy            high from acceptance until done/fail
//   mc_trigger/cmd/data_send   command launch towards the controller
//   mc_readout/busy/error      controller status and last read byte
// POLL_GAP must be at least 1.
module qspi_page_write_sequencer #(
  parameter int POLL_GAP       = 64,
  parameter int TIMEOUT_CYCLES = 160_000_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_erase,
  input  logic [23:0]   req_addr,
  input  logic [2047:0] req_data,
  output logic          done,
  output logic          fail,
  output logic [1:0]    fail_code,
  output logic          seq_busy,
  output logic          mc_trigger,
  output logic [7:0]    mc_cmd,
  output logic [2071:0] mc_data_send,
  input  logic [7:0]    mc_readout,
  input  logic          mc_busy,
  input  logic          mc_error
);

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_SE   = 8'hD8;
  localparam logic [7:0] CMD_PP   = 8'h02;

  localparam logic [1:0] FC_WEL = 2'd1;
  localparam logic [1:0] FC_MC  = 2'd2;
  localparam logic [1:0] FC_TO  = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_CHECK, S_GAP
  } state_e;

  // Step order matters: a successful step advances to step+1.
  typedef enum logic [2:0] {
    P_WREN1, P_WEL1, P_SE, P_POLL1, P_WREN2, P_WEL2, P_PP, P_POLL2
  } step_e;

  state_e          state_q, state_d;
  step_e           step_q, step_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [2071:0]   ds_q, ds_d;
  logic [23:0]     addr_q, addr_d;
  logic [2047:0]   data_q, data_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic [1:0]      fcode_q, fcode_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   to_q, to_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic            launch, end_ok, end_fail;
  step_e           launch_step;
  logic [1:0]      end_code;
  logic            is_poll, timed_out;
  logic            unused_readout;

  assign unused_readout = ^mc_readout[7:2];

  assign is_poll   = (step_q == P_POLL1) || (step_q == P_POLL2);
  assign timed_out = (to_q >= TO_LIMIT);

  assign req_ready    = (state_q == S_IDLE) && !mc_busy;
  assign mc_trigger   = (state_q == S_ISSUE);
  assign mc_cmd       = cmd_q;
  assign mc_data_send = ds_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign fail_code    = fcode_q;
  assign seq_busy     = busy_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= P_WREN1;
      cmd_q   <= '0;
      ds_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      fcode_q <= '0;
      busy_q  <= 1'b0;
      to_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cmd_q   <= cmd_d;
      ds_q    <= ds_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      fcode_q <= fcode_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cmd_d       = cmd_q;
    ds_d        = ds_q;
    addr_d      = addr_q;
    data_d      = data_q;
    done_d      = 1'b0;
    fail_d      = fail_q;
    fcode_d     = fcode_q;
    busy_d      = busy_q;
    to_d        = to_q;
    gap_d       = gap_q;
    launch      = 1'b0;
    launch_step = step_q;
    end_ok      = 1'b0;
    end_fail    = 1'b0;
    end_code    = '0;

    // Poll-phase timer covers command, settle, wait and gap cycles alike;
    // it saturates so the comparison stays valid for any wait length.
    if (state_q != S_IDLE && is_poll && !timed_out) to_d = to_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d      = req_addr;
          data_d      = req_data;
          fail_d      = 1'b0;
          fcode_d     = '0;
          busy_d      = 1'b1;
          launch      = 1'b1;
          launch_step = req_erase ? P_WREN1 : P_WREN2;
        end
      end
      S_ISSUE:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_CHECK;
      S_CHECK: begin
        // Never abandon a command in flight; results are only read once idle.
        if (!mc_busy) begin
          if (mc_error) begin
            end_fail = 1'b1;
            end_code = FC_MC;
          end else begin
            case (step_q)
              P_WEL1, P_WEL2: begin
                if (!mc_readout[1]) begin
                  end_fail = 1'b1;
                  end_code = FC_WEL;
                end else begin
                  launch      = 1'b1;
                  launch_step = step_e'(step_q + 3'd1);
                end
              end
              P_POLL1, P_POLL2: begin
                // WIP clear wins even if the timer expired this cycle.
                if (!mc_readout[0]) begin
                  if (step_q == P_POLL2) begin
                    end_ok = 1'b1;
                  end else begin
                    launch      = 1'b1;
                    launch_step = step_e'(step_q + 3'd1);
                  end
                end else if (timed_out) begin
                  end_fail = 1'b1;
                  end_code = FC_TO;
                end else begin
                  state_d = S_GAP;
                  gap_d   = '0;
                end
              end
              default: begin
                launch      = 1'b1;
                launch_step = step_e'(step_q + 3'd1);
              end
            endcase
          end
        end
      end
      S_GAP: begin
        if (timed_out) begin
          end_fail = 1'b1;
          end_code = FC_TO;
        end else if (gap_q == GAP_LAST) begin
          launch      = 1'b1;
          launch_step = step_q;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d = S_ISSUE;
      step_d  = launch_step;
      case (launch_step)
        P_WREN1, P_WREN2: cmd_d = CMD_WREN;
        P_SE: begin
          cmd_d = CMD_SE;
          ds_d  = {addr_q, 2048'h0};
        end
        P_PP: begin
          cmd_d = CMD_PP;
          ds_d  = {addr_q, data_q};
        end
        default: cmd_d = CMD_RDSR;
      endcase
      // Entering a poll phase from SE/PP restarts the timer; a re-poll from
      // the gap keeps counting.
      if ((launch_step == P_POLL1 || launch_step == P_POLL2) && step_q != launch_step)
        to_d = '0;
    end

    if (end_ok) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = S_IDLE;
    end

    if (end_fail) begin
      fail_d  = 1'b1;
      fcode_d = end_code;
      busy_d  = 1'b0;
      state_d = S_IDLE;
    end
  end

endmodule

// File: tb/tb_qspi_page_write_sequencer.sv
// Bench for qspi_page_write_sequencer: a simple controller model answers
// commands. The expected command list and outcome for each request are built
// from the write-sequence rules. A single monitor checks every trigger and
// every done/fail event against them.
module tb_qspi_page_write_sequencer;
  localparam int POLL_GAP = 16;
  localparam int TIMEOUT  = 1000;
  localparam int LAT      = 5;
  localparam logic [7:0] WREN = 8'h06, RDSR = 8'h05, SE = 8'hD8, PP = 8'h02;

  logic          clk = 1'b0, reset = 1'b0;
  logic          req_valid = 1'b0, req_erase = 1'b0;
  logic [23:0]   req_addr = '0;
  logic [2047:0] req_data = '0;
  logic          req_ready, done, fail, seq_busy, mc_trigger;
  logic [1:0]    fail_code;
  logic [7:0]    mc_cmd;
  logic [2071:0] mc_data_send;
  logic [7:0]    mc_readout = '0;
  logic          mc_busy = 1'b0, mc_error = 1'b0;

  always #5 clk = ~clk;

  qspi_page_write_sequencer #(.POLL_GAP(POLL_GAP), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_erase(req_erase), .req_addr(req_addr), .req_data(req_data),
    .done(done), .fail(fail), .fail_code(fail_code), .seq_busy(seq_busy),
    .mc_trigger(mc_trigger), .mc_cmd(mc_cmd), .mc_data_send(mc_data_send),
    .mc_readout(mc_readout), .mc_busy(mc_busy), .mc_error(mc_error)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Controller model behaviour knobs
  bit m_wel_ok = 1'b1, m_err_pp = 1'b0, m_stuck = 1'b0;
  int m_wip_n = 0;

  logic [7:0] cur_cmd_m = '0, prev_cmd_m = '0;
  int lat_cnt = 0, wip_left = 0;

  always @(posedge clk) begin
    if (mc_trigger) begin
      mc_busy   <= 1'b1;
      lat_cnt   <= LAT;
      cur_cmd_m <= mc_cmd;
    end else if (mc_busy) begin
      if (lat_cnt > 1) lat_cnt <= lat_cnt - 1;
      else begin
        mc_busy    <= 1'b0;
        prev_cmd_m <= cur_cmd_m;
        mc_error   <= (cur_cmd_m == PP) && m_err_pp;
        if (cur_cmd_m == RDSR) begin
          if (prev_cmd_m == WREN) mc_readout <= m_wel_ok ? 8'h02 : 8'h00;
          else if (wip_left > 0) begin
            mc_readout <= 8'h03;
            wip_left   <= wip_left - 1;
          end else mc_readout <= 8'h00;
        end else if (cur_cmd_m == SE || cur_cmd_m == PP) begin
          wip_left <= m_stuck ? 1_000_000 : m_wip_n;
        end
      end
    end
  end

  // Expectation model
  logic [7:0]    exp_q[$];
  bit            tail_rdsr = 1'b0, armed = 1'b0;
  int            exp_code = 0;
  int            ntrig = 0, ndone = 0;
  logic [23:0]   cur_addr = '0;
  logic [2047:0] cur_data = '0;
  logic [2071:0] prev_ds = '0;
  logic [7:0]    last_cmd = '0;
  int            last_trig_cyc = 0, poll_start_cyc = 0, fail_cyc = 0;

  task automatic build(input bit erase, input bit wel_ok, input int wip_n, input bit err_pp, input bit stuck);
    exp_q.delete();
    tail_rdsr = 1'b0;
    if (erase) begin
      exp_q.push_back(WREN); exp_q.push_back(RDSR);
      if (!wel_ok) begin exp_code = 1; return; end
      exp_q.push_back(SE);
      for (int i = 0; i <= wip_n; i++) exp_q.push_back(RDSR);
    end
    exp_q.push_back(WREN); exp_q.push_back(RDSR);
    if (!wel_ok) begin exp_code = 1; return; end
    exp_q.push_back(PP);
    if (err_pp) begin exp_code = 2; return; end
    if (stuck) begin tail_rdsr = 1'b1; exp_code = 3; return; end
    for (int i = 0; i <= wip_n; i++) exp_q.push_back(RDSR);
    exp_code = 0;
  endtask

  // Monitor
  initial begin
    logic [7:0] e;
    logic prev_trig, prev_fail;
    prev_trig = 1'b0;
    prev_fail = 1'b0;
    forever begin
      @(negedge clk);
      if (mc_trigger) begin
        ntrig++;
        chk(!prev_trig, "trig_single", 64'(prev_trig), 64'd0);
        chk(!mc_busy, "trig_ctrl_idle", 64'(mc_busy), 64'd0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk(mc_cmd == e, "cmd_order", 64'(mc_cmd), 64'(e));
        end else if (tail_rdsr) begin
          chk(mc_cmd == RDSR, "cmd_poll_tail", 64'(mc_cmd), 64'(RDSR));
        end else begin
          chk(1'b0, "unexpected_trigger", 64'(mc_cmd), 64'd0);
        end
        if (mc_cmd == SE)
          chk(mc_data_send == {cur_addr, 2048'h0}, "se_data",
              64'(mc_data_send[2071:2048]), 64'(cur_addr));
        else if (mc_cmd == PP)
          chk(mc_data_send == {cur_addr, cur_data}, "pp_data",
              64'(mc_data_send[2071:2008]), 64'({cur_addr, cur_data[2047:2008]}));
        else
          chk(mc_data_send == prev_ds, "data_hold",
              64'(mc_data_send[2071:2008]), 64'(prev_ds[2071:2008]));
        if (mc_cmd == RDSR && last_cmd == RDSR)
          chk(cyc - last_trig_cyc > POLL_GAP, "poll_gap", 64'(cyc - last_trig_cyc), 64'(POLL_GAP + 1));
        if (mc_cmd == RDSR && last_cmd == PP) poll_start_cyc = cyc;
        last_cmd      = mc_cmd;
        last_trig_cyc = cyc;
        prev_ds       = mc_data_send;
      end
      if (done) begin
        ndone++;
        chk(armed && exp_code == 0, "done_expected", 64'(armed), 64'd1);
        chk(!seq_busy, "done_busy_low", 64'(seq_busy), 64'd0);
        armed = 1'b0;
      end
      if (fail && !prev_fail) begin
        chk(armed, "fail_expected", 64'(armed), 64'd1);
        chk(fail_code == 2'(exp_code), "fail_code", 64'(fail_code), 64'(exp_code));
        chk(!seq_busy, "fail_busy_low", 64'(seq_busy), 64'd0);
        fail_cyc = cyc;
        armed = 1'b0;
      end
      prev_trig = mc_trigger;
      prev_fail = fail;
    end
  end

  task automatic issue_req(input bit erase, input logic [23:0] addr);
    int k;
    cur_addr = addr;
    for (int i = 0; i < 64; i++) cur_data[i*32 +: 32] = $urandom;
    ntrig = 0;
    ndone = 0;
    armed = 1'b1;
    @(negedge clk);
    req_erase = erase;
    req_addr  = addr;
    req_data  = cur_data;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 500) begin @(negedge clk); k++; end
    chk(req_ready, "req_ready_wait", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_data  = ~cur_data;
    @(negedge clk);
    chk(seq_busy && !fail, "accept_busy_nofail", 64'({seq_busy, fail}), 64'b10);
  endtask

  task automatic run_req(input bit erase, input logic [23:0] addr, input bit wel_ok, input int wip_n,
                         input bit err_pp, input bit stuck, input int lit_ntrig, input int lit_code);
    int k;
    m_wel_ok = wel_ok; m_wip_n = wip_n; m_err_pp = err_pp; m_stuck = stuck;
    build(erase, wel_ok, wip_n, err_pp, stuck);
    issue_req(erase, addr);
    k = 0;
    while (armed && k < 5000) begin @(negedge clk); k++; end
    chk(!armed, "outcome_timeout", 64'(k), 64'd5000);
    repeat (40) @(negedge clk);
    chk(exp_q.size() == 0, "all_cmds_issued", 64'(exp_q.size()), 64'd0);
    if (lit_ntrig >= 0) chk(ntrig == lit_ntrig, "trigger_count", 64'(ntrig), 64'(lit_ntrig));
    if (lit_code == 0) begin
      chk(ndone == 1 && !fail, "one_done", 64'(ndone), 64'd1);
    end else begin
      chk(ndone == 0 && fail && fail_code == 2'(lit_code), "fail_result", 64'(fail_code), 64'(lit_code));
    end
    chk(req_ready && !seq_busy, "idle_after", 64'({req_ready, seq_busy}), 64'b10);
  endtask

  initial begin
    int k;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(!mc_trigger && mc_cmd == 8'h00, "reset_cmd", 64'(mc_cmd), 64'd0);
    chk(mc_data_send == '0, "reset_data_send", 64'(mc_data_send[63:0]), 64'd0);
    chk(!done && !fail && fail_code == 2'd0 && !seq_busy, "reset_status",
        64'({done, fail, fail_code, seq_busy}), 64'd0);
    chk(req_ready, "reset_req_ready", 64'(req_ready), 64'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: program only, WIP high for three polls
    run_req(1'b0, 24'h012300, 1'b1, 3, 1'b0, 1'b0, 7, 0);
    // 2: erase then program
    run_req(1'b1, 24'hA30000, 1'b1, 2, 1'b0, 1'b0, 12, 0);
    // 3: WEL never set
    run_req(1'b1, 24'h004400, 1'b0, 0, 1'b0, 1'b0, 2, 1);
    // 4: controller error on PP (also checks fail clears on acceptance)
    run_req(1'b0, 24'h7FFF00, 1'b1, 0, 1'b1, 1'b0, 3, 2);
    // 5: WIP stuck -> timeout
    run_req(1'b0, 24'h100000, 1'b1, 0, 1'b0, 1'b1, -1, 3);
    chk(fail_cyc - poll_start_cyc >= TIMEOUT && fail_cyc - poll_start_cyc <= TIMEOUT + POLL_GAP + LAT + 8,
        "timeout_window", 64'(fail_cyc - poll_start_cyc), 64'(TIMEOUT));

    // 6: reset in the middle of a poll
    m_wel_ok = 1'b1; m_wip_n = 0; m_err_pp = 1'b0; m_stuck = 1'b1;
    build(1'b0, 1'b1, 0, 1'b0, 1'b1);
    issue_req(1'b0, 24'h200100);
    k = 0;
    while (ntrig < 5 && k < 2000) begin @(negedge clk); k++; end
    chk(ntrig >= 5, "reached_poll", 64'(ntrig), 64'd5);
    @(posedge clk);
    #1;
    armed = 1'b0;
    tail_rdsr = 1'b0;
    exp_q.delete();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    prev_ds = '0;
    @(negedge clk);
    chk(!mc_trigger && !done && !fail && !seq_busy, "reset_abandon",
        64'({mc_trigger, done, fail, seq_busy}), 64'd0);
    k = 0;
    while (mc_busy && k < 100) begin
      chk(!req_ready && !mc_trigger, "ready_held_off", 64'({req_ready, mc_trigger}), 64'd0);
      @(negedge clk);
      k++;
    end
    chk(req_ready, "ready_after_ctrl_idle", 64'(req_ready), 64'd1);
    repeat (20) @(negedge clk);
    chk(!done && !fail, "no_outcome_after_reset", 64'({done, fail}), 64'd0);
    run_req(1'b0, 24'h300200, 1'b1, 0, 1'b0, 1'b0, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
